ic_prio_loader: RTL and testbench

- APB master that programs the interrupt controller's per-peripheral priority registers from a selectable pattern.
- Boot-time configuration sequencer: it sits between system control (start/mode) and the ic APB slave port, and drives one write per peripheral index.
- Reports completion, APB errors and timeouts.

---
 rtl/ic_prio_loader.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ic_prio_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ic_prio_loader.sv
// ic_prio_loader
//   Boot-time APB master that writes one priority value per peripheral index
//   into the interrupt controller, using a selectable data pattern.
//
//   Optional build macro: IC_LOAD_VERIFY_EN
//     When defined, a read-back pass follows the write pass, and every
//     register is compared against the pattern that was written to it.
//
// Ports
//   pclk, prst          clock, asynchronous active-high reset
//   start               begin a load sequence (sampled in IDLE only)
//   mode                0 ascending, 1 descending, 2 constant, 3 LFSR
//   const_val           data for mode 2
//   seed                LFSR seed for mode 3 (0 selects 16'hACE1)
//   psel, penable       APB handshake
//   pwr_rd_en           1 = write, 0 = read
//   paddr, pwdata       APB address / write data
//   prdata              APB read data (read-back pass only)
//   pready, perror      APB slave ready / error
//   busy                sequence in progress
//   done                one-cycle pulse on successful completion
//   err, err_addr       sticky error flag and the failing index
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_SETUP   | APB setup phase of a write
//   S_ACCESS  | APB access phase of a write, waiting for pready
//   S_VSETUP  | APB setup phase of a read-back (verify build only)
//   S_VACCESS | APB access phase of a read-back (verify build only)
//   S_FIN     | one-cycle done pulse
module ic_prio_loader #(
   parameter int PERIPHERALS = 16,
   parameter int WIDTH       = $clog2(PERIPHERALS),
   parameter int TIMEOUT     = 15
) (
   input  logic             pclk,
   input  logic             prst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] const_val,
   input  logic [15:0]      seed,
   output logic             psel,
   output logic             penable,
   output logic             pwr_rd_en,
   output logic [WIDTH-1:0] paddr,
   output logic [WIDTH-1:0] pwdata,
   input  logic [WIDTH-1:0] prdata,
   input  logic             pready,
   input  logic             perror,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] err_addr
);

   localparam int              CW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]   WAIT_LOAD    = CW'(TIMEOUT - 1);
   localparam logic [WIDTH-1:0] LAST_IDX    = WIDTH'(PERIPHERALS - 1);
   localparam logic [15:0]     LFSR_DEFAULT = 16'hACE1;

`ifdef IC_LOAD_VERIFY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ACCESS, S_FIN, S_VSETUP, S_VACCESS
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_SETUP, S_ACCESS, S_FIN
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] index_q, index_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] const_q, const_d;
   logic [CW-1:0]    wcnt_q, wcnt_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] err_addr_q, err_addr_d;
   logic [WIDTH-1:0] pat;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      // Fibonacci taps 16,14,13,11 on a left shift
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [15:0] seed_eff(input logic [15:0] s);
      return (s == 16'h0000) ? LFSR_DEFAULT : s;
   endfunction

   function automatic logic [WIDTH-1:0] pattern(input logic [1:0]       m,
                                                input logic [WIDTH-1:0] idx,
                                                input logic [WIDTH-1:0] c,
                                                input logic [15:0]      l);
      case (m)
         2'd0:    return idx;
         2'd1:    return LAST_IDX - idx;
         2'd2:    return c;
         default: return l[WIDTH-1:0];
      endcase
   endfunction

`ifdef IC_LOAD_VERIFY_EN
   // Effective seed kept for re-seeding the LFSR at the start of read-back
   logic [15:0] seed_q, seed_d;
`else
   logic unused_prdata;
   assign unused_prdata = ^prdata;
`endif

   assign pat      = pattern(mode_q, index_q, const_q, lfsr_q);
   assign err      = err_q;
   assign err_addr = err_addr_q;

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         state_q    <= S_IDLE;
         index_q    <= '0;
         lfsr_q     <= '0;
         mode_q     <= '0;
         const_q    <= '0;
         wcnt_q     <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
`ifdef IC_LOAD_VERIFY_EN
         seed_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         lfsr_q     <= lfsr_d;
         mode_q     <= mode_d;
         const_q    <= const_d;
         wcnt_q     <= wcnt_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
`ifdef IC_LOAD_VERIFY_EN
         seed_q     <= seed_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      lfsr_d     = lfsr_q;
      mode_d     = mode_q;
      const_d    = const_q;
      wcnt_d     = wcnt_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
`ifdef IC_LOAD_VERIFY_EN
      seed_d     = seed_q;
`endif
      psel       = 1'b0;
      penable    = 1'b0;
      pwr_rd_en  = 1'b0;
      paddr      = '0;
      pwdata     = '0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d     = mode;
               const_d    = const_val;
               lfsr_d     = seed_eff(seed);
`ifdef IC_LOAD_VERIFY_EN
               seed_d     = seed_eff(seed);
`endif
               index_d    = '0;
               err_d      = 1'b0;
               err_addr_d = '0;
               state_d    = S_SETUP;
            end
         end

         S_SETUP: begin
            psel      = 1'b1;
            pwr_rd_en = 1'b1;
            paddr     = index_q;
            pwdata    = pat;
            busy      = 1'b1;
            wcnt_d    = WAIT_LOAD;
            state_d   = S_ACCESS;
         end

         S_ACCESS: begin
            psel      = 1'b1;
            penable   = 1'b1;
            pwr_rd_en = 1'b1;
            paddr     = index_q;
            pwdata    = pat;
            busy      = 1'b1;
            if (pready) begin
               if (perror) begin
                  err_d      = 1'b1;
                  err_addr_d = index_q;
                  state_d    = S_IDLE;
               end else if (index_q == LAST_IDX) begin
`ifdef IC_LOAD_VERIFY_EN
                  index_d = '0;
                  lfsr_d  = seed_q;
                  state_d = S_VSETUP;
`else
                  lfsr_d  = lfsr_step(lfsr_q);
                  state_d = S_FIN;
`endif
               end else begin
                  index_d = index_q + 1'b1;
                  lfsr_d  = lfsr_step(lfsr_q);
                  state_d = S_SETUP;
               end
            end else if (wcnt_q == '0) begin
               err_d      = 1'b1;
               err_addr_d = index_q;
               state_d    = S_IDLE;
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end

`ifdef IC_LOAD_VERIFY_EN
         S_VSETUP: begin
            psel    = 1'b1;
            paddr   = index_q;
            busy    = 1'b1;
            wcnt_d  = WAIT_LOAD;
            state_d = S_VACCESS;
         end

         S_VACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            paddr   = index_q;
            busy    = 1'b1;
            if (pready) begin
               if (perror || (prdata != pat)) begin
                  err_d      = 1'b1;
                  err_addr_d = index_q;
                  state_d    = S_IDLE;
               end else if (index_q == LAST_IDX) begin
                  state_d = S_FIN;
               end else begin
                  index_d = index_q + 1'b1;
                  lfsr_d  = lfsr_step(lfsr_q);
                  state_d = S_VSETUP;
               end
            end else if (wcnt_q == '0) begin
               err_d      = 1'b1;
               err_addr_d = index_q;
               state_d    = S_IDLE;
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end
`endif

         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ic_prio_loader.sv
module tb_ic_prio_loader;
   localparam int N  = 16;
   localparam int W  = 4;
   localparam int TO = 15;
`ifdef IC_LOAD_VERIFY_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif

   logic         pclk = 1'b0;
   logic         prst;
   logic         start;
   logic [1:0]   mode;
   logic [W-1:0] const_val;
   logic [15:0]  seed;
   logic         psel, penable, pwr_rd_en;
   logic [W-1:0] paddr, pwdata, prdata;
   logic         pready, perror;
   logic         busy, done, err;
   logic [W-1:0] err_addr;

   ic_prio_loader #(.PERIPHERALS(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .pclk(pclk), .prst(prst), .start(start), .mode(mode),
      .const_val(const_val), .seed(seed), .psel(psel), .penable(penable),
      .pwr_rd_en(pwr_rd_en), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .perror(perror), .busy(busy), .done(done),
      .err(err), .err_addr(err_addr)
   );

   always #5 pclk = ~pclk;

   int vectors = 0;
   int miscompares = 0;

   // results of the last run_seq call
   int         done_cyc, nwr, nrd, last_acc;
   logic       fin_err;
   logic [W-1:0] fin_err_addr;
   int         expd [N];
   logic [W-1:0] mem [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   task automatic build_expected(input int md, input int cv, input int sd);
      logic [15:0] l;
      l = (sd[15:0] == 16'h0) ? 16'hACE1 : sd[15:0];
      for (int i = 0; i < N; i++) begin
         case (md)
            0:       expd[i] = i;
            1:       expd[i] = N - 1 - i;
            2:       expd[i] = cv % N;
            default: expd[i] = int'(l) % N;
         endcase
         l = lfsr_next(l);
      end
   endtask

   task automatic do_reset();
      @(negedge pclk);
      prst = 1'b1; start = 1'b0; pready = 1'b0; perror = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      prst = 1'b0;
   endtask

   // One load sequence against a model APB slave.
   // wait_n: wait states per access; err_idx: write index answered with perror;
   // hang_idx: write index never answered; corrupt_idx: read-back index returned wrong.
   task automatic run_seq(input int md, input int cv, input int sd, input int wait_n,
                          input int err_idx, input int hang_idx, input int corrupt_idx,
                          input bit hold);
      logic [W-1:0] s_addr, s_data;
      logic         s_wr;
      int           waited, acc_cnt;
      bit           finished;
      build_expected(md, cv, sd);
      done_cyc = -1; nwr = 0; nrd = 0; last_acc = 0; finished = 0;
      waited = 0; acc_cnt = 0; s_addr = '0; s_data = '0; s_wr = 1'b0;
      fin_err = 1'bx; fin_err_addr = 'x;
      @(negedge pclk);
      start = 1'b1; mode = md[1:0]; const_val = cv[W-1:0]; seed = sd[15:0];
      pready = 1'b0; perror = 1'b0;
      for (int cyc = 1; cyc < 1000 && !finished; cyc++) begin
         @(negedge pclk);
         if (cyc == 1) begin
            check("err_cleared_on_start", {err, err_addr}, '0);
            if (!hold) start = 1'b0;
            mode = 2'($urandom); const_val = W'($urandom); seed = 16'($urandom);
         end
         pready = 1'b0; perror = 1'b0; prdata = '0;
         if (psel && !penable) begin
            waited = 0; acc_cnt = 0;
            s_addr = paddr; s_data = pwdata; s_wr = pwr_rd_en;
            check("setup_busy", busy, 1);
            if (s_wr) begin
               check("setup_addr", paddr, nwr);
               check("setup_data", pwdata, expd[nwr % N]);
               nwr++;
            end else begin
               check("vsetup_addr", paddr, nrd);
               check("vsetup_wdata", pwdata, 0);
               nrd++;
            end
         end else if (psel && penable) begin
            acc_cnt++;
            check("access_stable", {busy, paddr, pwdata, pwr_rd_en}, {1'b1, s_addr, s_data, s_wr});
            if (!(s_wr && int'(paddr) == hang_idx) && waited >= wait_n) begin
               pready = 1'b1;
               if (s_wr) begin
                  perror = (int'(paddr) == err_idx);
                  if (!perror) mem[paddr] = pwdata;
               end else begin
                  prdata = mem[paddr] ^ ((int'(paddr) == corrupt_idx) ? W'(1) : W'(0));
               end
            end
            waited++;
         end else begin
            fin_err = err; fin_err_addr = err_addr;
            if (done) done_cyc = cyc;
            else check("idle_after_abort", busy, 0);
            last_acc = acc_cnt;
            finished = 1;
         end
      end
      if (!finished) check("cycle_budget", 0, 1);
      if (done_cyc >= 0) begin
         @(negedge pclk);
         check("done_one_cycle", done, 0);
         if (hold) begin
            check("hold_idle_gap", psel, 0);
            @(negedge pclk);
            check("hold_restart_setup", {psel, penable, paddr}, {1'b1, 1'b0, W'(0)});
            start = 1'b0;
         end
      end
   endtask

   initial begin
      prst = 1'b1; start = 1'b0; mode = '0; const_val = '0; seed = '0;
      pready = 1'b0; perror = 1'b0; prdata = '0;
      for (int i = 0; i < N; i++) mem[i] = '0;
      #23;
      check("reset_apb", {psel, penable, pwr_rd_en, paddr, pwdata}, '0);
      check("reset_status", {busy, done, err, err_addr}, '0);
      @(negedge pclk);
      prst = 1'b0;

      // ascending, zero-wait
      run_seq(0, 0, 0, 0, -1, -1, -1, 0);
      check("m0_done_cycle", done_cyc, 1 + PASSES * N * 2);
      check("m0_writes", nwr, N);
      check("m0_err", fin_err, 0);

      // descending, 3 wait states each access
      run_seq(1, 0, 0, 3, -1, -1, -1, 0);
      check("m1_done_cycle", done_cyc, 1 + PASSES * N * 5);
      check("m1_err", fin_err, 0);

      // constant with slave error at index 5
      run_seq(2, 7, 0, 0, 5, -1, -1, 0);
      check("m2_writes", nwr, 6);
      check("m2_no_done", done_cyc, -1);
      check("m2_err", {fin_err, fin_err_addr}, {1'b1, W'(5)});

      // LFSR, seed 0 twice (first data 1 comes from 16'hACE1)
      build_expected(3, 0, 0);
      check("lfsr_first_model", expd[0], 1);
      run_seq(3, 0, 0, 0, -1, -1, -1, 0);
      check("m3a_done_cycle", done_cyc, 1 + PASSES * N * 2);
      run_seq(3, 0, 0, 1, -1, -1, -1, 0);
      check("m3b_done_cycle", done_cyc, 1 + PASSES * N * 3);

      // randomized sequences
      for (int k = 0; k < 6; k++) begin
         int md, cv, sd, wn;
         md = int'($urandom_range(0, 3));
         cv = int'($urandom_range(0, N - 1));
         sd = int'($urandom_range(0, 65535));
         wn = int'($urandom_range(0, 2));
         run_seq(md, cv, sd, wn, -1, -1, -1, 0);
         check("rand_done_cycle", done_cyc, 1 + PASSES * N * (2 + wn));
         check("rand_err", fin_err, 0);
      end

      // timeout on index 2
      run_seq(0, 0, 0, 0, -1, 2, -1, 0);
      check("to_access_cycles", last_acc, TO);
      check("to_err", {fin_err, fin_err_addr}, {1'b1, W'(2)});
      check("to_no_done", done_cyc, -1);

`ifdef IC_LOAD_VERIFY_EN
      // corrupted read-back at index 9
      run_seq(0, 0, 0, 0, -1, -1, 9, 0);
      check("vfy_writes", nwr, N);
      check("vfy_reads", nrd, 10);
      check("vfy_err", {fin_err, fin_err_addr}, {1'b1, W'(9)});
`endif

      // start held across FIN restarts right after it
      run_seq(0, 0, 0, 0, -1, -1, -1, 1);
      check("hold_done_cycle", done_cyc, 1 + PASSES * N * 2);
      do_reset();

      // asynchronous reset in the middle of an access
      @(negedge pclk);
      start = 1'b1; mode = 2'd0; pready = 1'b0;
      @(negedge pclk);
      start = 1'b0;
      @(negedge pclk);
      check("pre_rst_access", {psel, penable, busy}, 3'b111);
      #2 prst = 1'b1;
      #1;
      check("async_rst_apb", {psel, penable, busy}, 3'b000);
      check("async_rst_done", done, 0);
      @(negedge pclk);
      prst = 1'b0;
      @(negedge pclk);
      check("post_rst_idle", {psel, busy, err}, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
